// File: rtl/calc_pkg.sv
// +-----------------------------------------------------------------+
// | calc_pkg: shared calculator number/op types and arbiter states  |
// | rev 1.0                                                         |
// +-----------------------------------------------------------------+
`default_nettype none

package calc_pkg;

  localparam int unsigned NumW = 16;

  typedef struct packed {
    logic            error;
    logic [NumW-1:0] val;
  } num_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } arb_state_t;

  function automatic num_t errorNum();
    num_t n;
    n       = '0;
    n.error = 1'b1;
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_arbiter_rr_picker.sv
// +-----------------------------------------------------------------+
// | rr_picker: rotate-and-priority-encode round-robin grant logic   |
// | rev 1.0                                                         |
// +-----------------------------------------------------------------+
`default_nettype none

module rr_picker #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic                 grant_valid_o,
  output logic [$clog2(N)-1:0] grant_idx_o
);

  localparam int IW = $clog2(N);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IW-1:0]  off;
  logic [IW:0]    sum;

  // Rotating by ptr puts the highest-priority requester at bit 0.
  assign dbl = {req_i, req_i} >> ptr_i;
  assign rot = dbl[N-1:0];

  always_comb begin
    grant_valid_o = 1'b0;
    off           = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        grant_valid_o = 1'b1;
        off           = IW'(i);
      end
    end
  end

  always_comb begin
    sum = {1'b0, ptr_i} + {1'b0, off};
    if (sum >= (IW + 1)'(N)) begin
      sum = sum - (IW + 1)'(N);
    end
    grant_idx_o = sum[IW-1:0];
  end

endmodule

`default_nettype wire

// File: rtl/alu_arbiter.sv
// +-----------------------------------------------------------------+
// | alu_arbiter: round-robin sharing of one ALU with hang timeout   |
// | rev 1.0                                                         |
// +-----------------------------------------------------------------+
`default_nettype none

module alu_arbiter
  import calc_pkg::*;
#(
  parameter int NumReq        = 2,
  parameter int TimeoutCycles = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  num_t [NumReq-1:0]        req_left_i,
  input  num_t [NumReq-1:0]        req_right_i,
  input  op_t  [NumReq-1:0]        req_op_i,
  input  logic [NumReq-1:0]        req_in_valid_i,
  output logic [NumReq-1:0]        req_in_ready_o,
  output num_t [NumReq-1:0]        req_result_o,
  output logic [NumReq-1:0]        req_out_valid_o,
  input  logic [NumReq-1:0]        req_out_ready_i,
  output num_t                     alu_left_o,
  output num_t                     alu_right_o,
  output op_t                      alu_op_o,
  output logic                     alu_in_valid_o,
  input  logic                     alu_in_ready_i,
  input  num_t                     alu_result_i,
  input  logic                     alu_out_valid_i,
  output logic                     alu_out_ready_o,
  output logic                     timeout_o
);

  localparam int IdxW   = $clog2(NumReq);
  localparam int TimerW = $clog2(TimeoutCycles + 1);

  arb_state_t      state_q,   state_d;
  logic [IdxW-1:0] rr_ptr_q,  rr_ptr_d;
  logic [IdxW-1:0] owner_q,   owner_d;
  num_t            left_q,    left_d;
  num_t            right_q,   right_d;
  op_t             op_q,      op_d;
  num_t            result_q,  result_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic            timeout_q, timeout_d;

  logic            grant_valid;
  logic [IdxW-1:0] grant_idx;
  logic            expired;

  rr_picker #(
    .N (NumReq)
  ) u_picker (
    .req_i         (req_in_valid_i),
    .ptr_i         (rr_ptr_q),
    .grant_valid_o (grant_valid),
    .grant_idx_o   (grant_idx)
  );

  assign expired = (timer_q == TimerW'(TimeoutCycles - 1));

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    owner_d        = owner_q;
    left_d         = left_q;
    right_d        = right_q;
    op_d           = op_q;
    result_d       = result_q;
    timer_d        = timer_q;
    timeout_d      = 1'b0;
    req_in_ready_o = '0;

    case (state_q)
      S_IDLE: begin
        if (grant_valid && rst_ni) begin
          req_in_ready_o[grant_idx] = 1'b1;
          left_d  = req_left_i[grant_idx];
          right_d = req_right_i[grant_idx];
          op_d    = req_op_i[grant_idx];
          owner_d = grant_idx;
          timer_d = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = timer_q + 1'b1;
        if (expired) begin
          result_d  = errorNum();
          timeout_d = 1'b1;
          state_d   = S_RESP;
        end else if (alu_in_ready_i) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        timer_d = timer_q + 1'b1;
        // A result arriving on the expiry cycle beats the timeout.
        if (alu_out_valid_i) begin
          result_d = alu_result_i;
          state_d  = S_RESP;
        end else if (expired) begin
          result_d  = errorNum();
          timeout_d = 1'b1;
          state_d   = S_RESP;
        end
      end
      S_RESP: begin
        if (req_out_ready_i[owner_q]) begin
          rr_ptr_d = (owner_q == IdxW'(NumReq - 1)) ? '0 : owner_q + 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= '0;
      owner_q   <= '0;
      left_q    <= '0;
      right_q   <= '0;
      op_q      <= OP_ADD;
      result_q  <= '0;
      timer_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      owner_q   <= owner_d;
      left_q    <= left_d;
      right_q   <= right_d;
      op_q      <= op_d;
      result_q  <= result_d;
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
    end
  end

  assign alu_left_o      = left_q;
  assign alu_right_o     = right_q;
  assign alu_op_o        = op_q;
  assign alu_in_valid_o  = rst_ni && (state_q == S_ISSUE);
  assign alu_out_ready_o = rst_ni && (state_q == S_WAIT);
  assign timeout_o       = rst_ni && timeout_q;

  always_comb begin
    req_out_valid_o = '0;
    if (rst_ni && (state_q == S_RESP)) begin
      req_out_valid_o[owner_q] = 1'b1;
    end
  end

  for (genvar g = 0; g < NumReq; g++) begin : g_bcast
    assign req_result_o[g] = result_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// +-----------------------------------------------------------------+
// | tb_alu_arbiter: directed self-checking bench for alu_arbiter    |
// | rev 1.0                                                         |
// +-----------------------------------------------------------------+
`default_nettype none

module tb_alu_arbiter;
  import calc_pkg::*;

  localparam int NR = 2;
  localparam int TC = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  num_t [NR-1:0] req_left, req_right, res;
  op_t  [NR-1:0] req_op;
  logic [NR-1:0] in_valid, in_ready, out_valid, out_ready;
  num_t alu_left, alu_right, alu_result;
  op_t  alu_op;
  logic alu_in_valid, alu_in_ready, alu_out_valid, alu_out_ready, timeout;

  logic hold_in_ready = 1'b0;
  logic mute          = 1'b0;
  logic pend;
  num_t pres;

  int nvec = 0;
  int nmis = 0;

  alu_arbiter #(
    .NumReq        (NR),
    .TimeoutCycles (TC)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .req_left_i      (req_left),
    .req_right_i     (req_right),
    .req_op_i        (req_op),
    .req_in_valid_i  (in_valid),
    .req_in_ready_o  (in_ready),
    .req_result_o    (res),
    .req_out_valid_o (out_valid),
    .req_out_ready_i (out_ready),
    .alu_left_o      (alu_left),
    .alu_right_o     (alu_right),
    .alu_op_o        (alu_op),
    .alu_in_valid_o  (alu_in_valid),
    .alu_in_ready_i  (alu_in_ready),
    .alu_result_i    (alu_result),
    .alu_out_valid_i (alu_out_valid),
    .alu_out_ready_o (alu_out_ready),
    .timeout_o       (timeout)
  );

  task automatic chk(input string tag, input logic [127:0] obs_v, input logic [127:0] exp_v);
    nvec++;
    if (obs_v !== exp_v) begin
      nmis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs_v, exp_v);
    end
  endtask

  function automatic num_t mk(input logic e, input logic [NumW-1:0] v);
    num_t n;
    n.error = e;
    n.val   = v;
    return n;
  endfunction

  function automatic num_t alu_f(input op_t o, input num_t l, input num_t r);
    num_t n;
    n = '0;
    case (o)
      OP_ADD: n.val = l.val + r.val;
      OP_SUB: n.val = l.val - r.val;
      OP_MUL: n.val = l.val * r.val;
      default: begin
        if (r.val == '0) n = errorNum();
        else             n.val = l.val / r.val;
      end
    endcase
    return n;
  endfunction

  // One-cycle-latency ALU; mute swallows accepted operations.
  assign alu_in_ready  = !hold_in_ready;
  assign alu_out_valid = pend;
  assign alu_result    = pres;

  always @(posedge clk) begin
    if (!rst_n) begin
      pend <= 1'b0;
      pres <= '0;
    end else if (alu_in_valid && alu_in_ready) begin
      pend <= !mute;
      pres <= alu_f(alu_op, alu_left, alu_right);
    end else if (alu_out_valid && alu_out_ready) begin
      pend <= 1'b0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out();
    int n = 0;
    while (out_valid == '0 && n < 20) begin
      cyc();
      n++;
    end
  endtask

  task automatic do_txn(input logic r, input logic [NumW-1:0] l, input logic [NumW-1:0] rt,
                        input op_t o, input logic [NumW-1:0] exp);
    logic [NR-1:0] oh;
    oh           = 2'b01 << r;
    req_left[r]  = mk(1'b0, l);
    req_right[r] = mk(1'b0, rt);
    req_op[r]    = o;
    in_valid     = oh;
    #1;
    chk("txn_grant", in_ready, oh);
    cyc();
    in_valid = '0;
    wait_out();
    chk("txn_owner", out_valid, oh);
    chk("txn_result", res[r], mk(1'b0, exp));
    cyc();
  endtask

  initial begin
    logic          own;
    logic [NR-1:0] oh;
    int            k [NR];
    num_t          expv;

    rst_n     = 1'b0;
    in_valid  = 2'b11;
    out_ready = 2'b00;
    req_left  = '0;
    req_right = '0;
    req_op    = {OP_ADD, OP_ADD};
    repeat (2) cyc();
    chk("rst_in_ready", in_ready, 2'b00);
    chk("rst_alu_in_valid", alu_in_valid, 1'b0);
    chk("rst_alu_out_ready", alu_out_ready, 1'b0);
    chk("rst_out_valid", out_valid, 2'b00);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_result", res[0], mk(1'b0, 16'd0));

    // Single request: 3 + 4 from requester 0.
    in_valid = '0;
    rst_n    = 1'b1;
    cyc();
    out_ready   = 2'b11;
    req_left[0] = mk(1'b0, 16'd3);
    req_right[0] = mk(1'b0, 16'd4);
    req_op[0]   = OP_ADD;
    in_valid    = 2'b01;
    #1;
    chk("single_ready", in_ready, 2'b01);
    cyc();
    in_valid = '0;
    chk("single_issue", alu_in_valid, 1'b1);
    chk("single_left", alu_left, mk(1'b0, 16'd3));
    chk("single_op", alu_op, OP_ADD);
    cyc();
    chk("single_wait", alu_out_ready, 1'b1);
    cyc();
    chk("single_out_valid", out_valid, 2'b01);
    chk("single_result", res[0], mk(1'b0, 16'd7));
    cyc();
    chk("single_done", out_valid, 2'b00);

    // Contention: rr_ptr is now 1, so grants go 1,0,1,0...
    k[0] = 0;
    k[1] = 0;
    for (int r = 0; r < NR; r++) begin
      req_left[r]  = mk(1'b0, NumW'(r));
      req_right[r] = mk(1'b0, NumW'(r + 2));
      req_op[r]    = (r == 0) ? OP_ADD : OP_MUL;
    end
    in_valid = 2'b11;
    own      = 1'b1;
    for (int t = 0; t < 16; t++) begin
      oh = 2'b01 << own;
      #1;
      chk("cont_grant", in_ready, oh);
      expv = (own == 1'b0) ? mk(1'b0, NumW'(10 * k[0] + 2))
                           : mk(1'b0, NumW'((10 * k[1] + 1) * 3));
      cyc();
      k[own]++;
      req_left[own] = mk(1'b0, NumW'(10 * k[own] + int'(own)));
      wait_out();
      chk("cont_owner", out_valid, oh);
      chk("cont_result", res[own], expv);
      cyc();
      own = ~own;
    end
    in_valid = '0;

    // Backpressure on both ALU input and requester output.
    hold_in_ready = 1'b1;
    out_ready     = 2'b00;
    req_left[1]   = mk(1'b0, 16'd9);
    req_right[1]  = mk(1'b0, 16'd2);
    req_op[1]     = OP_SUB;
    req_left[0]   = mk(1'b0, 16'd5);
    req_right[0]  = mk(1'b0, 16'd5);
    req_op[0]     = OP_ADD;
    in_valid      = 2'b11;
    #1;
    chk("bp_grant", in_ready, 2'b10);
    cyc();
    in_valid = 2'b01;
    repeat (5) begin
      chk("bp_issue", {alu_in_valid, alu_left, alu_right, alu_op, in_ready},
          {1'b1, mk(1'b0, 16'd9), mk(1'b0, 16'd2), OP_SUB, 2'b00});
      cyc();
    end
    hold_in_ready = 1'b0;
    cyc();
    cyc();
    repeat (3) begin
      chk("bp_resp_hold", {out_valid, res[1], in_ready}, {2'b10, mk(1'b0, 16'd7), 2'b00});
      cyc();
    end
    out_ready = 2'b11;
    cyc();
    do_txn(1'b0, 16'd5, 16'd5, OP_ADD, 16'd10);

    // Timeout: ALU swallows the operation.
    mute = 1'b1;
    req_left[1]  = mk(1'b0, 16'd1);
    req_right[1] = mk(1'b0, 16'd1);
    req_op[1]    = OP_ADD;
    in_valid     = 2'b10;
    #1;
    chk("to_grant", in_ready, 2'b10);
    cyc();
    in_valid = '0;
    repeat (7) begin
      cyc();
      chk("to_early", timeout, 1'b0);
    end
    cyc();
    chk("to_pulse", timeout, 1'b1);
    chk("to_resp", {out_valid, res[1]}, {2'b10, errorNum()});
    chk("to_alu_drop", {alu_in_valid, alu_out_ready}, 2'b00);
    cyc();
    chk("to_one_cycle", timeout, 1'b0);
    mute = 1'b0;
    do_txn(1'b0, 16'd2, 16'd2, OP_ADD, 16'd4);

    // Race: result arrives on the expiry cycle.
    hold_in_ready = 1'b1;
    req_left[0]   = mk(1'b0, 16'd5);
    req_right[0]  = mk(1'b0, 16'd6);
    req_op[0]     = OP_ADD;
    in_valid      = 2'b01;
    #1;
    chk("race_grant", in_ready, 2'b01);
    cyc();
    in_valid = '0;
    repeat (6) cyc();
    hold_in_ready = 1'b0;
    cyc();
    chk("race_wait", {alu_out_valid, alu_out_ready}, 2'b11);
    cyc();
    chk("race_timeout", timeout, 1'b0);
    chk("race_resp", {out_valid, res[0]}, {2'b01, mk(1'b0, 16'd11)});
    cyc();

    // Reset while waiting on the ALU; rr_ptr is 1 here.
    mute = 1'b1;
    req_left[0]  = mk(1'b0, 16'd7);
    req_right[0] = mk(1'b0, 16'd1);
    in_valid     = 2'b01;
    #1;
    chk("mrst_grant", in_ready, 2'b01);
    cyc();
    in_valid = '0;
    cyc();
    chk("mrst_in_wait", alu_out_ready, 1'b1);
    rst_n = 1'b0;
    cyc();
    chk("mrst_outputs", {in_ready, out_valid, alu_in_valid, alu_out_ready, timeout}, 7'd0);
    chk("mrst_operand", alu_left, mk(1'b0, 16'd0));
    rst_n = 1'b1;
    mute  = 1'b0;
    cyc();
    chk("mrst_no_resp", out_valid, 2'b00);
    req_left[0]  = mk(1'b0, 16'd8);
    req_right[0] = mk(1'b0, 16'd8);
    req_left[1]  = mk(1'b0, 16'd1);
    req_right[1] = mk(1'b0, 16'd1);
    in_valid     = 2'b11;
    #1;
    chk("mrst_first_grant", in_ready, 2'b01);
    cyc();
    in_valid = '0;
    wait_out();
    chk("mrst_result", {out_valid, res[0]}, {2'b01, mk(1'b0, 16'd16)});
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

`default_nettype wire
